arb_out_queue: RTL and testbench

//  Tagged FIFO directly downstream of the 4-input fixed-priority Arbiter.

---
 rtl/arb_out_queue.sv | 123 ++++++++++++
 tb/tb_arb_out_queue.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_out_queue.sv
// -----------------------------------------------------------------------------
// arb_out_queue
//   Tagged FIFO placed directly after the 4-input fixed-priority arbiter. Each
//   arbiter grant (payload plus the index of the winning input) is captured and
//   held until the consumer takes it. A stalled consumer therefore does not
//   stall arbitration until the queue is full.
//
// Parameters
//   WIDTH  payload width (matches arbiter io_out_bits)
//   TAG_W  tag width (matches arbiter io_chosen)
//   DEPTH  number of entries, power of two, >= 2
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high; empties the queue
//   io_enq_ready  queue can accept an entry (not full)
//   io_enq_valid  entry offered by the arbiter
//   io_enq_bits   offered payload
//   io_enq_tag    offered source index
//   io_deq_ready  consumer accepts the head entry
//   io_deq_valid  head entry valid
//   io_deq_bits   head payload
//   io_deq_tag    head source index
//   io_count      occupancy, 0..DEPTH
//
// Configuration macro
//   ARB_OUT_QUEUE_FLOW_EN  when defined, an entry offered to an empty queue
//                          is presented on the deq side in the same cycle and
//                          bypasses storage if the consumer takes it at once.
// -----------------------------------------------------------------------------
module arb_out_queue #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     io_enq_ready,
  input  logic                     io_enq_valid,
  input  logic [WIDTH-1:0]         io_enq_bits,
  input  logic [TAG_W-1:0]         io_enq_tag,
  input  logic                     io_deq_ready,
  output logic                     io_deq_valid,
  output logic [WIDTH-1:0]         io_deq_bits,
  output logic [TAG_W-1:0]         io_deq_tag,
  output logic [$clog2(DEPTH):0]   io_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]         enq_ptr;
  logic [PTR_W-1:0]         deq_ptr;
  logic                     maybe_full;
  logic [TAG_W+WIDTH-1:0]   ram [DEPTH];

  logic                     ptr_match;
  logic                     empty;
  logic                     full;
  logic                     do_enq;
  logic                     do_deq;
  logic [TAG_W+WIDTH-1:0]   rd_entry;
  logic [PTR_W-1:0]         ptr_diff;

  // Equal pointers mean either empty or full; maybe_full records which,
  // since it remembers whether the last pointer movement was an enqueue.
  assign ptr_match    = (enq_ptr == deq_ptr);
  assign empty        = ptr_match & ~maybe_full;
  assign full         = ptr_match &  maybe_full;
  assign io_enq_ready = ~full;
  assign rd_entry     = ram[deq_ptr];

`ifdef ARB_OUT_QUEUE_FLOW_EN
  // Flow-through: an empty queue presents the offered entry directly. If the
  // consumer takes it in the same cycle nothing is stored and the stored-side
  // dequeue is suppressed because there is nothing stored to pop.
  assign io_deq_valid = ~empty | io_enq_valid;
  assign {io_deq_tag, io_deq_bits} = empty ? {io_enq_tag, io_enq_bits} : rd_entry;
  assign do_enq = io_enq_ready & io_enq_valid & ~(empty & io_deq_ready);
  assign do_deq = io_deq_ready & ~empty;
`else
  // Plain queue: the head is always read from storage, minimum latency 1.
  assign io_deq_valid = ~empty;
  assign {io_deq_tag, io_deq_bits} = rd_entry;
  assign do_enq = io_enq_ready & io_enq_valid;
  assign do_deq = io_deq_ready & io_deq_valid;
`endif

  // Occupancy: the pointer difference wraps to zero when full, so the full
  // case is substituted explicitly.
  assign ptr_diff = enq_ptr - deq_ptr;
  assign io_count = full ? FULL_COUNT : {1'b0, ptr_diff};

  // Storage is written only on an accepted enqueue and is deliberately not
  // reset; stale contents are never visible because deq_valid masks them.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      ram[enq_ptr] <= {io_enq_tag, io_enq_bits};
    end
  end

  // Pointer and fullness state. Pointers wrap by natural overflow because
  // DEPTH is a power of two. maybe_full only changes when exactly one side
  // moves, which is what distinguishes full from empty at equal pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) begin
        enq_ptr <= enq_ptr + PTR_W'(1);
      end
      if (do_deq) begin
        deq_ptr <= deq_ptr + PTR_W'(1);
      end
      if (do_enq != do_deq) begin
        maybe_full <= do_enq;
      end
    end
  end

endmodule

// File: tb/tb_arb_out_queue.sv
// -----------------------------------------------------------------------------
// tb_arb_out_queue
//   Directed testbench for arb_out_queue (WIDTH=8, TAG_W=2, DEPTH=4). A small
//   behavioural fixed-priority arbiter can be switched in front of the queue
//   for the arbiter-integration scenario.
// -----------------------------------------------------------------------------
module tb_arb_out_queue;

  localparam int WIDTH = 8;
  localparam int TAG_W = 2;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enq_valid_drv;
  logic [WIDTH-1:0] enq_bits_drv;
  logic [TAG_W-1:0] enq_tag_drv;
  logic             deq_ready;

  logic             dut_enq_valid;
  logic [WIDTH-1:0] dut_enq_bits;
  logic [TAG_W-1:0] dut_enq_tag;
  logic             enq_ready;
  logic             deq_valid;
  logic [WIDTH-1:0] deq_bits;
  logic [TAG_W-1:0] deq_tag;
  logic [2:0]       count;

  logic             arb_mode;
  logic [3:0]       arb_valid;
  logic [WIDTH-1:0] arb_bits [4];
  logic             arb_out_valid;
  logic [TAG_W-1:0] arb_chosen;
  logic [WIDTH-1:0] arb_out_bits;
  logic             arb_in_0_ready;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Behavioural fixed-priority arbiter: lowest valid index wins, input 0 is
  // ready whenever the output side is ready.
  always_comb begin
    arb_out_valid = |arb_valid;
    arb_chosen    = '0;
    for (int i = 3; i >= 0; i--) begin
      if (arb_valid[i]) arb_chosen = TAG_W'(i);
    end
    arb_out_bits = arb_bits[arb_chosen];
  end
  assign arb_in_0_ready = enq_ready;

  assign dut_enq_valid = arb_mode ? arb_out_valid : enq_valid_drv;
  assign dut_enq_bits  = arb_mode ? arb_out_bits  : enq_bits_drv;
  assign dut_enq_tag   = arb_mode ? arb_chosen    : enq_tag_drv;

  arb_out_queue #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_enq_ready (enq_ready),
    .io_enq_valid (dut_enq_valid),
    .io_enq_bits  (dut_enq_bits),
    .io_enq_tag   (dut_enq_tag),
    .io_deq_ready (deq_ready),
    .io_deq_valid (deq_valid),
    .io_deq_bits  (deq_bits),
    .io_deq_tag   (deq_tag),
    .io_count     (count)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    compared++;
    if (enq_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_enq_ready got %b want 1", enq_ready);
    end
    compared++;
    if (deq_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_deq_valid got %b want 0", deq_valid);
    end
    compared++;
    if (count !== 3'd0) begin
      mismatched++; $display("[TB] FAIL reset_count got %0d want 0", count);
    end
  endtask

  task automatic test_reset_mid_stream();
    deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enq_valid_drv = 1'b1;
      enq_bits_drv  = 8'h70 + 8'(i);
      enq_tag_drv   = 2'(i);
      step();
    end
    enq_valid_drv = 1'b0;
    #1;
    compared++;
    if (count !== 3'd3) begin
      mismatched++; $display("[TB] FAIL mid_pre_count got %0d want 3", count);
    end
    #1;
    reset = 1'b1;
    #1;
    compared++;
    if (deq_valid !== 1'b0 || enq_ready !== 1'b1 || count !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset got v=%b r=%b c=%0d want v=0 r=1 c=0", deq_valid, enq_ready, count);
    end
    step();
    reset = 1'b0;
    #1;
    compared++;
    if (deq_valid !== 1'b0 || count !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_release got v=%b c=%0d want v=0 c=0", deq_valid, count);
    end
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq_valid_drv = 1'b1;
      enq_bits_drv  = vals[i];
      enq_tag_drv   = 2'(i);
      step();
      compared++;
      if (count !== 3'(i + 1)) begin
        mismatched++; $display("[TB] FAIL fill_count%0d got %0d want %0d", i, count, i + 1);
      end
    end
    compared++;
    if (enq_ready !== 1'b0) begin
      mismatched++; $display("[TB] FAIL fill_full_ready got %b want 0", enq_ready);
    end
    enq_bits_drv = 8'h55;
    enq_tag_drv  = 2'd1;
    step();
    compared++;
    if (count !== 3'd4) begin
      mismatched++; $display("[TB] FAIL fill_fifth_count got %0d want 4", count);
    end
    compared++;
    if (deq_valid !== 1'b1 || deq_bits !== 8'h11 || deq_tag !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL fill_head got v=%b %h/%0d want 1 11/0", deq_valid, deq_bits, deq_tag);
    end
  endtask

  task automatic test_full_drain();
    enq_valid_drv = 1'b1;
    enq_bits_drv  = 8'h55;
    enq_tag_drv   = 2'd1;
    deq_ready     = 1'b1;
    #1;
    compared++;
    if (enq_ready !== 1'b0) begin
      mismatched++; $display("[TB] FAIL drain_ready_while_full got %b want 0", enq_ready);
    end
    step();
    enq_valid_drv = 1'b0;
    deq_ready     = 1'b0;
    #1;
    compared++;
    if (count !== 3'd3 || enq_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL drain_after got c=%0d r=%b want c=3 r=1", count, enq_ready);
    end
    compared++;
    if (deq_bits !== 8'h22 || deq_tag !== 2'd1) begin
      mismatched++; $display("[TB] FAIL drain_next_head got %h/%0d want 22/1", deq_bits, deq_tag);
    end
  endtask

  task automatic test_back_to_back();
    logic [TAG_W+WIDTH-1:0] model [$];
    logic [TAG_W+WIDTH-1:0] exp_entry;
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    model.push_back({2'd2, 8'h33});
    model.push_back({2'd3, 8'h44});
    #1;
    compared++;
    if (count !== 3'd2) begin
      mismatched++; $display("[TB] FAIL b2b_start_count got %0d want 2", count);
    end
    for (int i = 0; i < 10; i++) begin
      enq_valid_drv = 1'b1;
      enq_bits_drv  = 8'h60 + 8'(i);
      enq_tag_drv   = 2'(i);
      deq_ready     = 1'b1;
      #1;
      exp_entry = model.pop_front();
      model.push_back({enq_tag_drv, enq_bits_drv});
      compared++;
      if (deq_valid !== 1'b1 || {deq_tag, deq_bits} !== exp_entry) begin
        mismatched++;
        $display("[TB] FAIL b2b_head%0d got %h/%0d want %h/%0d", i, deq_bits, deq_tag,
                 exp_entry[7:0], exp_entry[9:8]);
      end
      step();
      compared++;
      if (count !== 3'd2) begin
        mismatched++; $display("[TB] FAIL b2b_count%0d got %0d want 2", i, count);
      end
    end
    enq_valid_drv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_entry = model.pop_front();
      compared++;
      if (deq_valid !== 1'b1 || {deq_tag, deq_bits} !== exp_entry) begin
        mismatched++;
        $display("[TB] FAIL b2b_tail%0d got %h/%0d want %h/%0d", i, deq_bits, deq_tag,
                 exp_entry[7:0], exp_entry[9:8]);
      end
      step();
    end
    deq_ready = 1'b0;
    #1;
    compared++;
    if (count !== 3'd0 || deq_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL b2b_end got c=%0d v=%b want c=0 v=0", count, deq_valid);
    end
  endtask

  task automatic test_flow();
    enq_valid_drv = 1'b1;
    enq_bits_drv  = 8'hA5;
    enq_tag_drv   = 2'd2;
    deq_ready     = 1'b1;
    #1;
`ifdef ARB_OUT_QUEUE_FLOW_EN
    compared++;
    if (deq_valid !== 1'b1 || deq_bits !== 8'hA5 || deq_tag !== 2'd2 || count !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL flow_same_cycle got v=%b %h/%0d c=%0d want 1 a5/2 c=0",
               deq_valid, deq_bits, deq_tag, count);
    end
    step();
    enq_valid_drv = 1'b0;
    #1;
    compared++;
    if (deq_valid !== 1'b0 || count !== 3'd0) begin
      mismatched++; $display("[TB] FAIL flow_after got v=%b c=%0d want v=0 c=0", deq_valid, count);
    end
`else
    compared++;
    if (deq_valid !== 1'b0 || count !== 3'd0) begin
      mismatched++; $display("[TB] FAIL flow_same_cycle got v=%b c=%0d want v=0 c=0", deq_valid, count);
    end
    step();
    enq_valid_drv = 1'b0;
    #1;
    compared++;
    if (deq_valid !== 1'b1 || deq_bits !== 8'hA5 || deq_tag !== 2'd2 || count !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL flow_next_cycle got v=%b %h/%0d c=%0d want 1 a5/2 c=1",
               deq_valid, deq_bits, deq_tag, count);
    end
    step();
    compared++;
    if (deq_valid !== 1'b0 || count !== 3'd0) begin
      mismatched++; $display("[TB] FAIL flow_drained got v=%b c=%0d want v=0 c=0", deq_valid, count);
    end
`endif
    deq_ready = 1'b0;
  endtask

  task automatic test_arbiter();
    for (int i = 0; i < 4; i++) arb_bits[i] = 8'hB0 + 8'(i);
    arb_valid = 4'hF;
    arb_mode  = 1'b1;
    deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++;
      if (arb_in_0_ready !== 1'b1) begin
        mismatched++; $display("[TB] FAIL arb_in0_ready%0d got %b want 1", i, arb_in_0_ready);
      end
      step();
      compared++;
      if (count !== 3'(i + 1)) begin
        mismatched++; $display("[TB] FAIL arb_count%0d got %0d want %0d", i, count, i + 1);
      end
    end
    compared++;
    if (arb_in_0_ready !== 1'b0) begin
      mismatched++; $display("[TB] FAIL arb_in0_ready_full got %b want 0", arb_in_0_ready);
    end
    step();
    compared++;
    if (count !== 3'd4) begin
      mismatched++; $display("[TB] FAIL arb_hold_count got %0d want 4", count);
    end
    arb_valid = 4'h0;
    arb_mode  = 1'b0;
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++;
      if (deq_valid !== 1'b1 || deq_bits !== 8'hB0 || deq_tag !== 2'd0) begin
        mismatched++;
        $display("[TB] FAIL arb_entry%0d got v=%b %h/%0d want 1 b0/0", i, deq_valid, deq_bits, deq_tag);
      end
      step();
    end
    deq_ready = 1'b0;
    #1;
    compared++;
    if (count !== 3'd0) begin
      mismatched++; $display("[TB] FAIL arb_end_count got %0d want 0", count);
    end
  endtask

  initial begin
    reset         = 1'b1;
    enq_valid_drv = 1'b0;
    enq_bits_drv  = '0;
    enq_tag_drv   = '0;
    deq_ready     = 1'b0;
    arb_mode      = 1'b0;
    arb_valid     = 4'h0;
    for (int i = 0; i < 4; i++) arb_bits[i] = '0;
    #2;
    test_reset();
    step();
    reset = 1'b0;
    step();
    test_reset_mid_stream();
    test_fill();
    test_full_drain();
    test_back_to_back();
    test_flow();
    test_arbiter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
